// File: rtl/fp_arb_pkg.sv
// Shared definitions for the shared floating-point unit arbiters.
package fp_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Cycles from the first go to done on the shared multiplier.
  localparam int MUL_LATENCY = 3;

  // Width of the HardFloat control input.
  localparam int FLOAT_CONTROL_WIDTH = 1;

  // Width of a requester index; never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request strictly after 'last', with wrap.
module rr_picker
  import fp_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int ID = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [ID-1:0] last,
  output logic [N-1:0]  grant_onehot,
  output logic [ID-1:0] grant_idx,
  output logic          any
);

  // Scan from farthest to nearest so the nearest candidate after 'last' wins.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves a latch.
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        grant_onehot      = '0;
        grant_onehot[idx] = 1'b1;
        grant_idx         = ID'(idx);
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/std_mulFN.sv
// Three-cycle floating-point multiplier with a go/done handshake.
// Subnormal inputs and tiny results are flushed to signed zero; invalid
// operations return the canonical quiet NaN.
module std_mulFN
  import fp_arb_pkg::*;
#(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int numWidth = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           go,
  input  logic [FLOAT_CONTROL_WIDTH-1:0] control,
  input  logic [numWidth-1:0]            left,
  input  logic [numWidth-1:0]            right,
  input  logic [2:0]                     roundingMode,
  output logic [numWidth-1:0]            out,
  output logic                           done
);

  localparam int BIAS = (1 << (expWidth - 1)) - 1;
  localparam int EMAX = (1 << expWidth) - 1;

  logic [expWidth-1:0]   a_exp, b_exp;
  logic [sigWidth-2:0]   a_frac, b_frac;
  logic [2*sigWidth-1:0] prod, prod_n;
  logic [sigWidth-1:0]   mant;
  logic [sigWidth:0]     mant_r;
  logic                  guard, sticky, inc, sign, ovf_to_max;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  int                    exp_i;
  logic [numWidth-1:0]   result;
  logic                  go_p1_q, go_p2_q;
  logic [numWidth-1:0]   prod_p1_q, prod_p2_q;

  // Tininess detection does not matter when tiny results flush to zero.
  logic unused_control;
  assign unused_control = ^control;

  // Single-cycle combinational multiply and round of the current operands.
  always_comb begin
    a_exp  = left[numWidth-2 -: expWidth];
    b_exp  = right[numWidth-2 -: expWidth];
    a_frac = left[sigWidth-2:0];
    b_frac = right[sigWidth-2:0];
    sign   = left[numWidth-1] ^ right[numWidth-1];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_inf  = (a_exp == '1) && (a_frac == '0);
    b_inf  = (b_exp == '1) && (b_frac == '0);
    a_nan  = (a_exp == '1) && (a_frac != '0);
    b_nan  = (b_exp == '1) && (b_frac != '0);

    prod   = {{sigWidth{1'b0}}, 1'b1, a_frac} * {{sigWidth{1'b0}}, 1'b1, b_frac};
    prod_n = prod[2*sigWidth-1] ? prod : (prod << 1);
    mant   = prod_n[2*sigWidth-1 -: sigWidth];
    guard  = prod_n[sigWidth-1];
    sticky = |prod_n[sigWidth-2:0];
    exp_i  = int'(a_exp) + int'(b_exp) - BIAS + (prod[2*sigWidth-1] ? 1 : 0);

    // HardFloat encodings: 0 near-even, 1 min-mag, 2 min, 3 max, 4 near-max-mag.
    case (roundingMode)
      3'd0:    inc = guard & (sticky | mant[0]);
      3'd2:    inc = sign & (guard | sticky);
      3'd3:    inc = ~sign & (guard | sticky);
      3'd4:    inc = guard;
      default: inc = 1'b0;
    endcase
    ovf_to_max = (roundingMode == 3'd1) || (roundingMode == 3'd2 && !sign) ||
                 (roundingMode == 3'd3 && sign);

    mant_r = {1'b0, mant} + {{sigWidth{1'b0}}, inc};
    if (mant_r[sigWidth]) begin
      mant_r = mant_r >> 1;
      exp_i  = exp_i + 1;
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      result = {1'b0, {expWidth{1'b1}}, 1'b1, {(sigWidth-2){1'b0}}};
    else if (a_inf || b_inf)
      result = {sign, {expWidth{1'b1}}, {(sigWidth-1){1'b0}}};
    else if (a_zero || b_zero)
      result = {sign, {(numWidth-1){1'b0}}};
    else if (exp_i >= EMAX)
      result = ovf_to_max ? {sign, {(expWidth-1){1'b1}}, 1'b0, {(sigWidth-1){1'b1}}}
                          : {sign, {expWidth{1'b1}}, {(sigWidth-1){1'b0}}};
    else if (exp_i <= 0)
      result = {sign, {(numWidth-1){1'b0}}};
    else
      result = {sign, expWidth'(exp_i), mant_r[sigWidth-2:0]};
  end

  // Track how long go has been held; done needs three consecutive go cycles.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      go_p1_q <= 1'b0;
      go_p2_q <= 1'b0;
    end else begin
      go_p1_q <= go;
      go_p2_q <= go_p1_q;
    end
  end

  // Product pipeline; qualified by done, so it carries no reset.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers skip reset; only control state needs a known value.
    prod_p1_q <= result;
    prod_p2_q <= prod_p1_q;
  end

  assign out  = prod_p2_q;
  assign done = go & go_p1_q & go_p2_q;

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one floating-point multiplier among NUM_REQ requesters.
module fp_mul_arbiter
  import fp_arb_pkg::*;
#(
  parameter  int EXP_WIDTH = 8,
  parameter  int SIG_WIDTH = 24,
  parameter  int NUM_WIDTH = 32,
  parameter  int NUM_REQ   = 4,
  localparam int ID_WIDTH  = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*NUM_WIDTH-1:0]   req_left,
  input  logic [NUM_REQ*NUM_WIDTH-1:0]   req_right,
  input  logic [FLOAT_CONTROL_WIDTH-1:0] control,
  input  logic [2:0]                     rounding_mode,
  output logic                           resp_valid,
  output logic [ID_WIDTH-1:0]            resp_id,
  output logic [NUM_WIDTH-1:0]           resp_out,
  output logic                           busy
);

  localparam logic [0:0]          S_IDLE   = IDLE;
  localparam logic [0:0]          S_BUSY   = BUSY;
  localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(NUM_REQ - 1);

  logic [0:0]                     state_q, state_d;
  logic [ID_WIDTH-1:0]            last_grant_q;
  logic [NUM_WIDTH-1:0]           left_q, right_q;
  logic [FLOAT_CONTROL_WIDTH-1:0] control_q;
  logic [2:0]                     rm_q;
  logic                           resp_valid_q;
  logic [ID_WIDTH-1:0]            resp_id_q;
  logic [NUM_WIDTH-1:0]           resp_out_q;

  logic [NUM_REQ-1:0]             grant_onehot;
  logic [ID_WIDTH-1:0]            grant_idx;
  logic                           grant_any;
  logic                           accept, resp_fire, mul_go, mul_done;
  logic [NUM_WIDTH-1:0]           mul_out;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req          (req_valid),
    .last         (last_grant_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  std_mulFN #(
    .expWidth (EXP_WIDTH),
    .sigWidth (SIG_WIDTH),
    .numWidth (NUM_WIDTH)
  ) u_mul (
    .clk          (clk),
    .reset        (reset),
    .go           (mul_go),
    .control      (control_q),
    .left         (left_q),
    .right        (right_q),
    .roundingMode (rm_q),
    .out          (mul_out),
    .done         (mul_done)
  );

  assign accept    = (state_q == S_IDLE) && grant_any && !reset;
  assign resp_fire = (state_q == S_BUSY) && mul_done;
  assign mul_go    = (state_q == S_BUSY);

  // Next-state: accept moves to BUSY, the multiplier's done returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_BUSY;
      S_BUSY:  if (resp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and the response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_RST;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_fire;
      if (accept)
        last_grant_q <= grant_idx;
      if (resp_fire) begin
        resp_id_q  <= last_grant_q;
        resp_out_q <= mul_out;
      end
    end
  end

  // Capture the winner's operands and the shared mode bits at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      left_q    <= req_left[int'(grant_idx)*NUM_WIDTH +: NUM_WIDTH];
      right_q   <= req_right[int'(grant_idx)*NUM_WIDTH +: NUM_WIDTH];
      control_q <= control;
      rm_q      <= rounding_mode;
    end
  end

  assign req_ready  = accept ? grant_onehot : '0;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_out   = resp_out_q;
  assign busy       = (state_q == S_BUSY) && !reset;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: single-op vector table plus multi-cycle sequences.
module tb_fp_mul_arbiter;
  import fp_arb_pkg::*;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int RESP_CYC = MUL_LATENCY + 1;

  logic                           clk = 1'b0;
  logic                           reset = 1'b1;
  logic [NR-1:0]                  req_valid = '0;
  logic [NR-1:0]                  req_ready;
  logic [NR*W-1:0]                req_left = '0;
  logic [NR*W-1:0]                req_right = '0;
  logic [FLOAT_CONTROL_WIDTH-1:0] control = '0;
  logic [2:0]                     rounding_mode = 3'd0;
  logic                           resp_valid;
  logic [1:0]                     resp_id;
  logic [W-1:0]                   resp_out;
  logic                           busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_arbiter #(.EXP_WIDTH(8), .SIG_WIDTH(24), .NUM_WIDTH(W), .NUM_REQ(NR)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_left      (req_left),
    .req_right     (req_right),
    .control       (control),
    .rounding_mode (rounding_mode),
    .resp_valid    (resp_valid),
    .resp_id       (resp_id),
    .resp_out      (resp_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         req;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_left[i*W +: W]  = a;
    req_right[i*W +: W] = b;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    cyc_start();
    cyc_start();
    reset = 1'b0;
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  vec_t vecs[12];
  int   fair_cnt[NR];
  logic [31:0] fair_prod[NR];
  logic [31:0] b2b_left[3];
  logic [31:0] b2b_prod[3];

  initial begin
    vecs[0]  = '{0, 32'h40000000, 32'h40400000, 3'd0, 32'h40C00000}; // 2*3
    vecs[1]  = '{1, 32'h3FC00000, 32'hC0800000, 3'd0, 32'hC0C00000}; // 1.5*-4
    vecs[2]  = '{2, 32'h40000000, 32'h40000000, 3'd0, 32'h40800000}; // 2*2
    vecs[3]  = '{3, 32'h00000000, 32'h40A00000, 3'd0, 32'h00000000}; // 0*5
    vecs[4]  = '{0, 32'h80000000, 32'h3F800000, 3'd0, 32'h80000000}; // -0*1
    vecs[5]  = '{1, 32'h7F800000, 32'h40000000, 3'd0, 32'h7F800000}; // inf*2
    vecs[6]  = '{2, 32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002}; // below half ulp, RNE
    vecs[7]  = '{3, 32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003}; // same, round up
    vecs[8]  = '{0, 32'h3F800001, 32'h3FC00000, 3'd0, 32'h3FC00002}; // tie, odd lsb -> up
    vecs[9]  = '{1, 32'h3F800001, 32'h3FC00000, 3'd1, 32'h3FC00001}; // tie, toward zero
    vecs[10] = '{2, 32'h3FFFFFFF, 32'h3FFFFFFF, 3'd0, 32'h407FFFFE}; // carry into exponent
    vecs[11] = '{3, 32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000}; // overflow -> inf

    // Reset values, sampled while reset is held.
    cyc_start();
    req_valid = 4'b1111;
    sample();
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_id", 64'(resp_id), 64'h0);
    check("rst_resp_out", 64'(resp_out), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    do_reset();

    // Table: one request at a time, response exactly RESP_CYC cycles after accept.
    for (int v = 0; v < 12; v++) begin
      int k;
      bit seen;
      set_op(vecs[v].req, vecs[v].a, vecs[v].b);
      rounding_mode = vecs[v].rm;
      req_valid     = onehot(vecs[v].req);
      sample();
      check($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(onehot(vecs[v].req)));
      cyc_start();
      req_valid = '0;
      seen = 1'b0;
      k = 1;
      while (!seen && k <= 8) begin
        sample();
        if (resp_valid) seen = 1'b1;
        else begin
          k++;
          cyc_start();
        end
      end
      check($sformatf("vec%0d_latency", v), 64'(k), 64'(RESP_CYC));
      check($sformatf("vec%0d_id", v), 64'(resp_id), 64'(vecs[v].req));
      check($sformatf("vec%0d_out", v), 64'(resp_out), 64'(vecs[v].exp));
      cyc_start();
    end
    rounding_mode = 3'd0;

    // Simultaneous req1/req2 after reset: req1 first (cycle 4), then req2 (cycle 8).
    do_reset();
    set_op(1, 32'h3FC00000, 32'hC0800000);
    set_op(2, 32'h40000000, 32'h40000000);
    req_valid = 4'b0110;
    for (int c = 0; c <= 9; c++) begin
      if (c == 5) req_valid = '0;
      sample();
      check($sformatf("sim_c%0d_ready", c), 64'(req_ready),
            (c == 0) ? 64'h2 : (c == 4) ? 64'h4 : 64'h0);
      check($sformatf("sim_c%0d_rv", c), 64'(resp_valid), 64'(c == 4 || c == 8));
      if (c == 4) begin
        check("sim_id1", 64'(resp_id), 64'h1);
        check("sim_out1", 64'(resp_out), 64'hC0C00000);
      end
      if (c == 8) begin
        check("sim_id2", 64'(resp_id), 64'h2);
        check("sim_out2", 64'(resp_out), 64'h40800000);
      end
      cyc_start();
    end

    // Fairness: all four held for 16 operations.
    do_reset();
    fair_prod[0] = 32'h40000000;
    fair_prod[1] = 32'h40800000;
    fair_prod[2] = 32'h40C00000;
    fair_prod[3] = 32'h41000000;
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h40000000, 32'h40000000);
    set_op(2, 32'h40400000, 32'h40000000);
    set_op(3, 32'h40800000, 32'h40000000);
    for (int i = 0; i < NR; i++) fair_cnt[i] = 0;
    req_valid = 4'b1111;
    for (int c = 0; c < 68; c++) begin
      bit exp_rv;
      if (c == 61) req_valid = '0;
      sample();
      if (c % 4 == 0)
        check($sformatf("fair_c%0d_ready", c), 64'(req_ready),
              (c <= 60) ? 64'(onehot((c / 4) % NR)) : 64'h0);
      exp_rv = (c % 4 == 0) && c >= 4 && c <= 64;
      check($sformatf("fair_c%0d_rv", c), 64'(resp_valid), 64'(exp_rv));
      if (exp_rv && resp_valid) begin
        check($sformatf("fair_c%0d_id", c), 64'(resp_id), 64'((c / 4 - 1) % NR));
        check($sformatf("fair_c%0d_out", c), 64'(resp_out), 64'(fair_prod[(c / 4 - 1) % NR]));
        fair_cnt[resp_id]++;
      end
      cyc_start();
    end
    for (int i = 0; i < NR; i++)
      check($sformatf("fair_count%0d", i), 64'(fair_cnt[i]), 64'd4);

    // Back-to-back: req3 held, new operand after each accept.
    do_reset();
    b2b_left[0] = 32'h3F800000; b2b_prod[0] = 32'h40400000;
    b2b_left[1] = 32'h40000000; b2b_prod[1] = 32'h40C00000;
    b2b_left[2] = 32'h40400000; b2b_prod[2] = 32'h41100000;
    set_op(3, b2b_left[0], 32'h40400000);
    req_valid = 4'b1000;
    for (int c = 0; c <= 13; c++) begin
      if (c == 1) set_op(3, b2b_left[1], 32'h40400000);
      if (c == 5) set_op(3, b2b_left[2], 32'h40400000);
      if (c == 9) req_valid = '0;
      sample();
      check($sformatf("b2b_c%0d_ready", c), 64'(req_ready),
            (c == 0 || c == 4 || c == 8) ? 64'h8 : 64'h0);
      check($sformatf("b2b_c%0d_rv", c), 64'(resp_valid), 64'(c == 4 || c == 8 || c == 12));
      if (c == 4 || c == 8 || c == 12) begin
        check($sformatf("b2b_c%0d_id", c), 64'(resp_id), 64'h3);
        check($sformatf("b2b_c%0d_out", c), 64'(resp_out), 64'(b2b_prod[c / 4 - 1]));
      end
      cyc_start();
    end

    // Reset mid-operation: op dropped, req0 wins again after reset.
    do_reset();
    set_op(0, 32'h40000000, 32'h40400000);
    set_op(1, 32'h3FC00000, 32'hC0800000);
    req_valid = 4'b0001;
    sample();
    check("rmid_c0_ready", 64'(req_ready), 64'h1);
    cyc_start();
    req_valid = '0;
    sample();
    check("rmid_c1_busy", 64'(busy), 64'h1);
    cyc_start();
    reset     = 1'b1;
    req_valid = 4'b0011;
    sample();
    check("rmid_c2_busy", 64'(busy), 64'h0);
    check("rmid_c2_ready", 64'(req_ready), 64'h0);
    check("rmid_c2_rv", 64'(resp_valid), 64'h0);
    cyc_start();
    reset = 1'b0;
    sample();
    check("rmid_c3_ready", 64'(req_ready), 64'h1);
    check("rmid_c3_rv", 64'(resp_valid), 64'h0);
    for (int c = 4; c <= 12; c++) begin
      cyc_start();
      if (c == 4) req_valid = 4'b0010;
      if (c == 8) req_valid = '0;
      sample();
      check($sformatf("rmid_c%0d_ready", c), 64'(req_ready), (c == 7) ? 64'h2 : 64'h0);
      check($sformatf("rmid_c%0d_rv", c), 64'(resp_valid), 64'(c == 7 || c == 11));
      if (c == 7) begin
        check("rmid_id0", 64'(resp_id), 64'h0);
        check("rmid_out0", 64'(resp_out), 64'h40C00000);
      end
      if (c == 11) begin
        check("rmid_id1", 64'(resp_id), 64'h1);
        check("rmid_out1", 64'(resp_out), 64'hC0C00000);
      end
    end
    cyc_start();

    // Operand stability: req_left[0] changes during BUSY must not leak through.
    set_op(0, 32'h40000000, 32'h40400000);
    req_valid = 4'b0001;
    sample();
    check("stab_ready", 64'(req_ready), 64'h1);
    for (int c = 1; c <= 4; c++) begin
      cyc_start();
      if (c == 1) begin
        req_valid = '0;
        req_left[0 +: W] = 32'h41200000;
      end
      if (c == 3) req_left[0 +: W] = 32'h40E00000;
      sample();
      check($sformatf("stab_c%0d_rv", c), 64'(resp_valid), 64'(c == 4));
    end
    check("stab_out", 64'(resp_out), 64'h40C00000);
    check("stab_id", 64'(resp_id), 64'h0);
    cyc_start();
    sample();
    check("stab_pulse_end", 64'(resp_valid), 64'h0);
    check("stab_out_hold", 64'(resp_out), 64'h40C00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
